// File: rtl/jmp_rvs_if.sv
// Dispatch, CDB and issue bundle between dispatch, the jump reservation station and the jump unit.
interface jmp_rvs_if #(
   parameter int DEPTH     = 4,
   parameter int TAG_W     = 4,
   parameter int ROB_DEPTH = 16,
   parameter int OPC_W     = 4
);
   localparam int PTR_W     = $clog2(DEPTH);
   localparam int ROB_PTR_W = $clog2(ROB_DEPTH);

   logic                 flush;
   logic                 disp_valid;
   logic                 disp_rdy;
   logic [OPC_W-1:0]     disp_opc;
   logic [ROB_PTR_W-1:0] disp_inst_id;
   logic [TAG_W-1:0]     disp_tag;
   logic [11:0]          disp_offset;
   logic                 disp_src1_rdy;
   logic [TAG_W-1:0]     disp_src1_tag;
   logic [31:0]          disp_src1_data;
   logic                 disp_src2_rdy;
   logic [TAG_W-1:0]     disp_src2_tag;
   logic [31:0]          disp_src2_data;
   logic                 cdb_valid;
   logic [TAG_W-1:0]     cdb_tag;
   logic [31:0]          cdb_wdata;
   logic                 req;
   logic                 rdy;
   logic [OPC_W-1:0]     opc;
   logic [ROB_PTR_W-1:0] inst_id;
   logic [TAG_W-1:0]     tag;
   logic [11:0]          offset;
   logic [31:0]          src1;
   logic [31:0]          src2;
   logic [PTR_W:0]       count;

   modport slave (
      input  flush, disp_valid, disp_opc, disp_inst_id, disp_tag, disp_offset,
             disp_src1_rdy, disp_src1_tag, disp_src1_data,
             disp_src2_rdy, disp_src2_tag, disp_src2_data,
             cdb_valid, cdb_tag, cdb_wdata, rdy,
      output disp_rdy, req, opc, inst_id, tag, offset, src1, src2, count
   );

   modport master (
      output flush, disp_valid, disp_opc, disp_inst_id, disp_tag, disp_offset,
             disp_src1_rdy, disp_src1_tag, disp_src1_data,
             disp_src2_rdy, disp_src2_tag, disp_src2_data,
             cdb_valid, cdb_tag, cdb_wdata, rdy,
      input  disp_rdy, req, opc, inst_id, tag, offset, src1, src2, count
   );
endinterface

// File: rtl/jmp_rvs.sv
// In-order reservation station for the branch/jump unit: FIFO of micro-ops, CDB wakeup, head-only issue.
// Optional JMP_RVS_CDB_BYPASS_EN lets the head issue in the same cycle its last operand is broadcast.
module jmp_rvs #(
   parameter int DEPTH     = 4,
   parameter int TAG_W     = 4,
   parameter int ROB_DEPTH = 16,
   parameter int OPC_W     = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   jmp_rvs_if.slave     bus
);
   localparam int PTR_W     = $clog2(DEPTH);
   localparam int ROB_PTR_W = $clog2(ROB_DEPTH);

   logic [DEPTH-1:0]     valid_q;
   logic [DEPTH-1:0]     s1_rdy_q;
   logic [DEPTH-1:0]     s2_rdy_q;
   logic [OPC_W-1:0]     opc_q     [DEPTH];
   logic [ROB_PTR_W-1:0] inst_id_q [DEPTH];
   logic [TAG_W-1:0]     tag_q     [DEPTH];
   logic [11:0]          offset_q  [DEPTH];
   logic [TAG_W-1:0]     s1_tag_q  [DEPTH];
   logic [TAG_W-1:0]     s2_tag_q  [DEPTH];
   logic [31:0]          s1_data_q [DEPTH];
   logic [31:0]          s2_data_q [DEPTH];

   logic [PTR_W:0]   wptr_q, wptr_d;
   logic [PTR_W:0]   rptr_q, rptr_d;
   logic [PTR_W-1:0] head;
   logic             full;
   logic             disp_fire;
   logic             issue_fire;
   logic             disp_cap1, disp_cap2;
   logic             s1_ok, s2_ok;
   logic [DEPTH-1:0] wr_en, clr_en, wake1, wake2;

   assign head      = rptr_q[PTR_W-1:0];
   assign full      = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                      (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
   assign disp_fire = bus.disp_valid && !full;
   assign disp_cap1 = !bus.disp_src1_rdy && bus.cdb_valid && (bus.cdb_tag == bus.disp_src1_tag);
   assign disp_cap2 = !bus.disp_src2_rdy && bus.cdb_valid && (bus.cdb_tag == bus.disp_src2_tag);

`ifdef JMP_RVS_CDB_BYPASS_EN
   logic s1_hit, s2_hit;
   assign s1_hit   = bus.cdb_valid && (bus.cdb_tag == s1_tag_q[head]);
   assign s2_hit   = bus.cdb_valid && (bus.cdb_tag == s2_tag_q[head]);
   assign s1_ok    = s1_rdy_q[head] || s1_hit;
   assign s2_ok    = s2_rdy_q[head] || s2_hit;
   assign bus.src1 = (!s1_rdy_q[head] && s1_hit) ? bus.cdb_wdata : s1_data_q[head];
   assign bus.src2 = (!s2_rdy_q[head] && s2_hit) ? bus.cdb_wdata : s2_data_q[head];
`else
   assign s1_ok    = s1_rdy_q[head];
   assign s2_ok    = s2_rdy_q[head];
   assign bus.src1 = s1_data_q[head];
   assign bus.src2 = s2_data_q[head];
`endif

   assign bus.req      = valid_q[head] && s1_ok && s2_ok;
   assign issue_fire   = bus.req && bus.rdy;
   assign bus.disp_rdy = !full;
   assign bus.opc      = opc_q[head];
   assign bus.inst_id  = inst_id_q[head];
   assign bus.tag      = tag_q[head];
   assign bus.offset   = offset_q[head];
   assign bus.count    = wptr_q - rptr_q;

   // Dispatch and issue never target the same slot: dispatch needs !full, issue needs !empty.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign wr_en[gi]  = disp_fire && (wptr_q[PTR_W-1:0] == PTR_W'(gi));
      assign clr_en[gi] = issue_fire && (head == PTR_W'(gi));
      assign wake1[gi]  = valid_q[gi] && !s1_rdy_q[gi] && bus.cdb_valid &&
                          (bus.cdb_tag == s1_tag_q[gi]);
      assign wake2[gi]  = valid_q[gi] && !s2_rdy_q[gi] && bus.cdb_valid &&
                          (bus.cdb_tag == s2_tag_q[gi]);
   end

   always_comb begin
      wptr_d = wptr_q + {{PTR_W{1'b0}}, disp_fire};
      rptr_d = rptr_q + {{PTR_W{1'b0}}, issue_fire};
      if (bus.flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         valid_q  <= '0;
         s1_rdy_q <= '0;
         s2_rdy_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            opc_q[i]     <= '0;
            inst_id_q[i] <= '0;
            tag_q[i]     <= '0;
            offset_q[i]  <= '0;
            s1_tag_q[i]  <= '0;
            s2_tag_q[i]  <= '0;
            s1_data_q[i] <= '0;
            s2_data_q[i] <= '0;
         end
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         for (int i = 0; i < DEPTH; i++) begin
            if (bus.flush) begin
               valid_q[i] <= 1'b0;
            end else if (wr_en[i]) begin
               valid_q[i]   <= 1'b1;
               opc_q[i]     <= bus.disp_opc;
               inst_id_q[i] <= bus.disp_inst_id;
               tag_q[i]     <= bus.disp_tag;
               offset_q[i]  <= bus.disp_offset;
               s1_rdy_q[i]  <= bus.disp_src1_rdy || disp_cap1;
               s1_tag_q[i]  <= bus.disp_src1_tag;
               s1_data_q[i] <= disp_cap1 ? bus.cdb_wdata : bus.disp_src1_data;
               s2_rdy_q[i]  <= bus.disp_src2_rdy || disp_cap2;
               s2_tag_q[i]  <= bus.disp_src2_tag;
               s2_data_q[i] <= disp_cap2 ? bus.cdb_wdata : bus.disp_src2_data;
            end else begin
               if (clr_en[i]) valid_q[i] <= 1'b0;
               if (wake1[i]) begin
                  s1_rdy_q[i]  <= 1'b1;
                  s1_data_q[i] <= bus.cdb_wdata;
               end
               if (wake2[i]) begin
                  s2_rdy_q[i]  <= 1'b1;
                  s2_data_q[i] <= bus.cdb_wdata;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_jmp_rvs.sv
// Directed bench for jmp_rvs: expected issues go into a scoreboard queue, a negedge monitor compares them.
module tb_jmp_rvs;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   jmp_rvs_if bus ();
   jmp_rvs dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   localparam logic [3:0] OP_BEQ = 4'd0;
   localparam logic [3:0] OP_JAL = 4'd8;

   typedef struct packed {
      logic [3:0]  opc;
      logic [3:0]  inst_id;
      logic [3:0]  tag;
      logic [11:0] offset;
      logic [31:0] src1;
      logic [31:0] src2;
   } exp_t;

   exp_t sb[$];
   exp_t mon_act, mon_exp;
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_disp(input logic [3:0] op, input logic [3:0] id, input logic [3:0] tg,
                           input logic [11:0] off,
                           input logic r1, input logic [3:0] t1, input logic [31:0] d1,
                           input logic r2, input logic [3:0] t2, input logic [31:0] d2);
      bus.disp_valid     = 1'b1;
      bus.disp_opc       = op;
      bus.disp_inst_id   = id;
      bus.disp_tag       = tg;
      bus.disp_offset    = off;
      bus.disp_src1_rdy  = r1;
      bus.disp_src1_tag  = t1;
      bus.disp_src1_data = d1;
      bus.disp_src2_rdy  = r2;
      bus.disp_src2_tag  = t2;
      bus.disp_src2_data = d2;
   endtask

   task automatic push(input logic [3:0] op, input logic [3:0] id, input logic [3:0] tg,
                       input logic [11:0] off, input logic [31:0] s1, input logic [31:0] s2);
      sb.push_back({op, id, tg, off, s1, s2});
   endtask

   // Every accepted issue is one transaction; it must match the oldest expected micro-op.
   always @(negedge clk) begin
      if (rst_n && bus.req && bus.rdy) begin
         mon_act = {bus.opc, bus.inst_id, bus.tag, bus.offset, bus.src1, bus.src2};
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL issue: unexpected issue %h, expected none", mon_act);
         end else begin
            mon_exp = sb.pop_front();
            if (mon_act !== mon_exp) begin
               errors++;
               $display("FAIL issue: got %h, expected %h", mon_act, mon_exp);
            end else begin
               $display("issue inst_id=%0d src1=%0h src2=%0h", bus.inst_id, bus.src1, bus.src2);
            end
         end
      end
   end

   initial begin
      bus.flush = 1'b0;
      bus.rdy = 1'b0;
      bus.cdb_valid = 1'b0;
      bus.cdb_tag = '0;
      bus.cdb_wdata = '0;
      set_disp(OP_BEQ, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      bus.disp_valid = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_req", 32'(bus.req), 0);
      chk("rst_disp_rdy", 32'(bus.disp_rdy), 1);
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_src1", bus.src1, 0);
      chk("rst_inst_id", 32'(bus.inst_id), 0);
      rst_n = 1'b1;
      tick();

      // beq with both sources ready
      bus.rdy = 1'b1;
      set_disp(OP_BEQ, 4'd1, 4'd1, 12'h010, 1, 0, 32'd5, 1, 0, 32'd5);
      push(OP_BEQ, 4'd1, 4'd1, 12'h010, 32'd5, 32'd5);
      tick();
      bus.disp_valid = 1'b0;
      chk("t1_req", 32'(bus.req), 1);
      chk("t1_count", 32'(bus.count), 1);
      tick();
      chk("t1_count_after", 32'(bus.count), 0);
      chk("t1_req_after", 32'(bus.req), 0);

      // jal waiting on tag 3, broadcast two cycles later
      set_disp(OP_JAL, 4'd2, 4'd2, 12'h020, 0, 4'd3, 32'd0, 1, 0, 32'd0);
      push(OP_JAL, 4'd2, 4'd2, 12'h020, 32'h100, 32'd0);
      tick();
      bus.disp_valid = 1'b0;
      chk("t2_req_wait", 32'(bus.req), 0);
      tick();
      bus.cdb_valid = 1'b1;
      bus.cdb_tag = 4'd3;
      bus.cdb_wdata = 32'h100;
`ifdef JMP_RVS_CDB_BYPASS_EN
      chk("t2_req_bcast", 32'(bus.req), 1);
      tick();
      bus.cdb_valid = 1'b0;
      chk("t2_count_next", 32'(bus.count), 0);
`else
      chk("t2_req_bcast", 32'(bus.req), 0);
      tick();
      bus.cdb_valid = 1'b0;
      chk("t2_req_next", 32'(bus.req), 1);
`endif
      tick();
      chk("t2_count_end", 32'(bus.count), 0);

      // Stalled head blocks a ready younger entry
      bus.rdy = 1'b0;
      set_disp(OP_BEQ, 4'd7, 4'd4, 12'h070, 0, 4'd2, 32'd0, 1, 0, 32'd9);
      push(OP_BEQ, 4'd7, 4'd4, 12'h070, 32'h22, 32'd9);
      tick();
      set_disp(OP_BEQ, 4'd8, 4'd5, 12'h080, 1, 0, 32'd1, 1, 0, 32'd2);
      push(OP_BEQ, 4'd8, 4'd5, 12'h080, 32'd1, 32'd2);
      tick();
      bus.disp_valid = 1'b0;
      chk("t3_req_stall", 32'(bus.req), 0);
      chk("t3_count", 32'(bus.count), 2);
      bus.rdy = 1'b1;
      tick();
      chk("t3_req_still", 32'(bus.req), 0);
      bus.cdb_valid = 1'b1;
      bus.cdb_tag = 4'd2;
      bus.cdb_wdata = 32'h22;
      tick();
      bus.cdb_valid = 1'b0;
      tick();
      tick();
      chk("t3_count_end", 32'(bus.count), 0);

      // Fill, reject a fifth dispatch, free one slot, dispatch across the pointer wrap
      bus.rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_disp(OP_BEQ, 4'(10 + i), 4'(i), 12'(4 * i), 1, 0, 32'(i + 1), 1, 0, 32'(i + 100));
         push(OP_BEQ, 4'(10 + i), 4'(i), 12'(4 * i), 32'(i + 1), 32'(i + 100));
         tick();
      end
      set_disp(OP_JAL, 4'd14, 4'd6, 12'h0e0, 1, 0, 32'h14, 1, 0, 32'h41);
      chk("t4_disp_rdy_full", 32'(bus.disp_rdy), 0);
      chk("t4_count_full", 32'(bus.count), 4);
      tick();
      chk("t4_count_rejected", 32'(bus.count), 4);
      bus.rdy = 1'b1;
      tick();
      bus.rdy = 1'b0;
      chk("t4_disp_rdy_freed", 32'(bus.disp_rdy), 1);
      chk("t4_count_freed", 32'(bus.count), 3);
      push(OP_JAL, 4'd14, 4'd6, 12'h0e0, 32'h14, 32'h41);
      tick();
      bus.disp_valid = 1'b0;
      chk("t4_count_wrap", 32'(bus.count), 4);

      // Issue outputs hold while the jump unit stalls
      for (int i = 0; i < 3; i++) begin
         chk("t5_req_hold", 32'(bus.req), 1);
         chk("t5_inst_hold", 32'(bus.inst_id), 11);
         chk("t5_src1_hold", bus.src1, 2);
         chk("t5_src2_hold", bus.src2, 101);
         tick();
      end
      bus.rdy = 1'b1;
      tick();
      tick();
      chk("t5_count_two", 32'(bus.count), 2);
      set_disp(OP_BEQ, 4'd15, 4'd7, 12'h0f0, 1, 0, 32'h15, 1, 0, 32'h51);
      push(OP_BEQ, 4'd15, 4'd7, 12'h0f0, 32'h15, 32'h51);
      tick();
      bus.disp_valid = 1'b0;
      chk("t5_count_simul", 32'(bus.count), 2);
      tick(); tick(); tick();
      chk("t5_count_drain", 32'(bus.count), 0);

      // Flush drops queued entries and a same-cycle dispatch
      bus.rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_disp(OP_BEQ, 4'(i), 4'(i), 12'h001, 1, 0, 32'd1, 1, 0, 32'd1);
         tick();
      end
      set_disp(OP_BEQ, 4'd3, 4'd3, 12'h001, 1, 0, 32'd1, 1, 0, 32'd1);
      bus.flush = 1'b1;
      chk("t6_count_pre", 32'(bus.count), 3);
      tick();
      bus.flush = 1'b0;
      bus.disp_valid = 1'b0;
      chk("t6_count_flush", 32'(bus.count), 0);
      chk("t6_req_flush", 32'(bus.req), 0);
      bus.rdy = 1'b1;
      tick(); tick(); tick();
      chk("t6_count_idle", 32'(bus.count), 0);
      bus.rdy = 1'b0;

      // Asynchronous reset mid-stream
      set_disp(OP_BEQ, 4'd12, 4'd1, 12'h002, 1, 0, 32'd3, 1, 0, 32'd4);
      tick();
      bus.disp_valid = 1'b0;
      chk("t7_req_before", 32'(bus.req), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t7_req_rst", 32'(bus.req), 0);
      chk("t7_count_rst", 32'(bus.count), 0);
      chk("t7_disp_rdy_rst", 32'(bus.disp_rdy), 1);
      tick();
      rst_n = 1'b1;
      tick();
      bus.rdy = 1'b1;
      set_disp(OP_JAL, 4'd13, 4'd2, 12'h003, 1, 0, 32'h31, 1, 0, 32'h13);
      push(OP_JAL, 4'd13, 4'd2, 12'h003, 32'h31, 32'h13);
      tick();
      bus.disp_valid = 1'b0;
      tick(); tick();
      chk("t7_count_end", 32'(bus.count), 0);
      chk("sb_empty", 32'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/jmp_rvs.md
# jmp_rvs

In-order reservation station feeding the branch/jump execution unit. It accepts dispatched branch and jump micro-ops and holds them until both source operands are available. While waiting, it captures operands broadcast on the CDB. It issues strictly in program order over the req/rdy execution-unit handshake, because the jump unit resolves flushes in allocation order and relies on issue order matching ROB order.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- PTR_W, $clog2(DEPTH), entry pointer width
- TAG_W, 4, physical register tag width
- ROB_DEPTH, 16, ROB entries
- ROB_PTR_W, $clog2(ROB_DEPTH), ROB id width
- OPC_W, 4, jmp_op_* opcode width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush; synchronous clear of all entries
- disp_valid  in  1  dispatch request
- disp_rdy  out  1  dispatch accept; equals ~full
- disp_opc  in  OPC_W  jmp_op_* opcode
- disp_inst_id  in  ROB_PTR_W  ROB id
- disp_tag  in  TAG_W  destination tag
- disp_offset  in  12  branch offset, halfword units
- disp_src{1,2}_rdy  in  1  operand value already valid
- disp_src{1,2}_tag  in  TAG_W  producer tag when not ready
- disp_src{1,2}_data  in  32  operand value when ready
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_wdata  in  32  broadcast value
- req  out  1  issue request to the jump unit
- rdy  in  1  jump unit can accept
- opc, inst_id, tag, offset, src1, src2  out  widths as above; issued micro-op
- count  out  PTR_W+1  occupancy

## Operation
- Each entry holds valid, opc, inst_id, tag, offset, and per source: rdy, tag, data.
- The circular FIFO uses wptr and rptr, each PTR_W+1 bits.
  - full: low bits equal, MSBs differ.
  - empty: pointers fully equal.
- Dispatch fires when disp_valid && disp_rdy. The micro-op is written at wptr and wptr increments.
  - Dispatch-time capture: if a source is not ready, cdb_valid=1, and cdb_tag matches that source's tag, the entry stores cdb_wdata and sets rdy.
- Wakeup: every cycle, each valid entry whose source is not ready and whose tag matches cdb_tag (with cdb_valid=1) latches cdb_wdata and sets rdy. All matching sources update in the same cycle.
- Issue:
  - req = head valid && src1 rdy && src2 rdy.
  - Issue outputs are driven combinationally from the head entry.
  - Issue fires when req && rdy. The head is invalidated and rptr increments.
  - Only the head may issue; a ready younger entry waits behind a stalled head.
- Simultaneous dispatch and issue in one cycle: both take effect and count is unchanged.
- disp_rdy depends only on registered state (~full). It does not look ahead to a same-cycle issue.
- flush=1 takes priority over dispatch, issue and wakeup in that cycle.
  - All entries are invalidated and both pointers are set to 0.
  - A dispatch presented in the flush cycle is dropped.
  - The same-cycle combinational issue handshake is still visible to the jump unit.
- Pointer and count arithmetic wraps modulo 2^(PTR_W+1).
- count = wptr − rptr.

## Timing
- Reset (rst_n=0, asynchronous) sets all entry valid bits, wptr, rptr and count to 0.
  - Outputs during reset: req=0, disp_rdy=1; issue data outputs read as 0.
  - Reset asserted mid-operation discards all entries immediately.
- Dispatch-to-req latency is 1 cycle when both sources are ready, or captured from the CDB, at dispatch.
- CDB wakeup-to-req latency is 1 cycle (without the bypass macro).
- Issue data must remain stable while req=1 and rdy=0.
- The entry freed by an issue can be reused by a dispatch on the following cycle.

## Configuration
- JMP_RVS_CDB_BYPASS_EN defined: when the head is valid and each non-ready source of the head matches the current CDB broadcast, req asserts in the same cycle.
  - src1/src2 are muxed from cdb_wdata.
  - If the issue fires, the entry is dequeued that cycle.
  - If the issue does not fire, the entry latches the value as normal.
- Undefined: operands reach the issue path only from entry storage, with the 1-cycle wakeup latency.

## Test plan
- Dispatch beq, both sources ready (src1=5, src2=5), rdy=1 -> req=1 next cycle with src1=src2=5 and opc=beq; count returns to 0 after issue.
- Dispatch jal with src1 waiting on tag 3; cdb_valid with tag 3, data 0x100, two cycles later -> req rises the cycle after the broadcast (or the same cycle with JMP_RVS_CDB_BYPASS_EN) with src1=0x100.
- Head waits on tag 2 while entry 1 is fully ready -> no req until tag 2 broadcasts; then issue order is entry 0, then entry 1 (inst_id 7, then 8).
- Fill 4 entries with rdy=0 -> disp_rdy=0 and count=4; a fifth dispatch is not accepted; one issue -> disp_rdy=1 the next cycle; then dispatch across the pointer wrap.
- Hold rdy=0 for 3 cycles with req=1 -> outputs stable throughout; simultaneous dispatch and issue with count=2 -> count stays 2.
- flush with 3 entries valid and disp_valid=1 -> count=0 and req=0 next cycle; dropped dispatch never issues. Assert rst_n=0 mid-stream -> req=0 immediately.
